// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stall requests into the stage stall vector,
// sequences exception flushes with a drain window, and monitors stall behaviour.
module pipe_ctrl #(
  parameter int unsigned  TIMEOUT      = 1024,
  parameter int unsigned  DRAIN_CYCLES = 2,
  parameter logic [31:0]  INT_VECTOR   = 32'h00000020,
  parameter logic [31:0]  EXC_VECTOR   = 32'h00000040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic {RUN, DRAIN} state_t;

  localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic [3:0]  drain_cnt, drain_cnt_nxt;
  logic [15:0] wdog, wdog_nxt;

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    stall         = '0;
    flush         = 1'b0;
    new_pc        = '0;
    unique case (state)
      RUN: begin
        if (stallreq_mem) begin
          // A pending exception waits behind the memory stall.
          stall = 6'b011111;
        end else if (excepttype != '0) begin
          flush         = 1'b1;
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
          case (excepttype)
            32'h00000001:                             new_pc = INT_VECTOR;
            32'h00000008, 32'h0000000a,
            32'h0000000c, 32'h0000000d:               new_pc = EXC_VECTOR;
            32'h0000000e:                             new_pc = cp0_epc;
            default:                                  new_pc = EXC_VECTOR;
          endcase
        end else if (stallreq_ex) begin
          stall = 6'b001111;
        end else if (stallreq_id) begin
          stall = 6'b000111;
        end else if (stallreq_if) begin
          stall = 6'b000011;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_nxt = RUN;
        else                 drain_cnt_nxt = drain_cnt - 4'd1;
      end
      default: state_nxt = RUN;
    endcase
    // Outputs are forced quiet for the whole time reset is held.
    if (rst) begin
      stall  = '0;
      flush  = 1'b0;
      new_pc = '0;
    end
  end

  always_comb begin
    wdog_nxt = '0;
    if (state == RUN && stall[0])
      wdog_nxt = (wdog == WDOG_LIMIT) ? wdog : wdog + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      drain_cnt     <= '0;
      wdog          <= '0;
      stall_timeout <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      wdog      <= wdog_nxt;
      if (wdog_nxt == WDOG_LIMIT) stall_timeout <= 1'b1;
      if (stall != '0)            stall_cycles  <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: constant vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_pipe_ctrl;
  localparam int          TO   = 4;
  localparam int          DR   = 2;
  localparam logic [31:0] INTV = 32'h00000020;
  localparam logic [31:0] EXCV = 32'h00000040;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sif = 1'b0, sid = 1'b0, sex = 1'b0, smem = 1'b0;
  logic [31:0] et = '0, epc = '0;
  logic [5:0]  stall;
  logic        flush, stall_timeout;
  logic [31:0] new_pc, stall_cycles;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(TO), .DRAIN_CYCLES(DR), .INT_VECTOR(INTV), .EXC_VECTOR(EXCV)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .excepttype(et), .cp0_epc(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
  );

  int checks = 0, failures = 0;

  // Model: m_drain = drain cycles still to spend (0 means running).
  int          m_drain, m_wd;
  logic        m_to;
  logic [31:0] m_cyc;
  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_pc;

  typedef struct {
    logic i_if, i_id, i_ex, i_mem;
    logic [31:0] et, epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
  } vec_t;
  vec_t tab[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_drain = 0; m_wd = 0; m_to = 1'b0; m_cyc = '0;
  endfunction

  function automatic void model_comb();
    int k;
    e_stall = '0; e_flush = 1'b0; e_pc = '0;
    if (m_drain == 0) begin
      if (et != 0 && !smem) begin
        e_flush = 1'b1;
        e_pc = (et == 32'd1) ? INTV : (et == 32'd14) ? epc : EXCV;
      end else begin
        // Deepest requesting stage k stalls itself and every stage before it.
        k = smem ? 4 : sex ? 3 : sid ? 2 : sif ? 1 : 0;
        e_stall = (k == 0) ? 6'd0 : 6'((1 << (k + 1)) - 1);
      end
    end
  endfunction

  function automatic void model_edge();
    if (m_drain > 0) begin
      m_drain--;
      m_wd = 0;
    end else begin
      if (e_flush) m_drain = DR;
      if (e_stall[0]) m_wd = (m_wd < TO) ? m_wd + 1 : TO;
      else            m_wd = 0;
    end
    if (m_wd == TO) m_to = 1'b1;
    if (e_stall != 0) m_cyc = m_cyc + 32'd1;
  endfunction

  task automatic drive(input logic a, b, c, d, input logic [31:0] x, y);
    sif = a; sid = b; sex = c; smem = d; et = x; epc = y;
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic cycle(input logic a, b, c, d, input logic [31:0] x, y);
    drive(a, b, c, d, x, y);
    #1;
    model_comb();
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("new_pc", new_pc, e_pc);
    @(posedge clk);
    #1;
    model_edge();
    chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
    chk("stall_cycles", stall_cycles, m_cyc);
  endtask

  task automatic cyc_exp(input logic a, b, c, d, input logic [31:0] x, y,
                         input logic [5:0] es, input logic ef, input logic [31:0] ep);
    drive(a, b, c, d, x, y);
    #1;
    chk("k_stall", 32'(stall), 32'(es));
    chk("k_flush", 32'(flush), 32'(ef));
    chk("k_new_pc", new_pc, ep);
    cycle(a, b, c, d, x, y);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #2;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_cycles", stall_cycles, 32'h0);
    chk("rst_timeout", 32'(stall_timeout), 32'h0);
    rst = 1'b0;
    model_reset();
  endtask

  logic [31:0] rx;

  initial begin
    tab[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,        6'b000000, 1'b0, 32'h0};
    tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,        6'b000011, 1'b0, 32'h0};
    tab[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        6'b000111, 1'b0, 32'h0};
    tab[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        6'b000111, 1'b0, 32'h0};
    tab[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        6'b001111, 1'b0, 32'h0};
    tab[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0,        6'b011111, 1'b0, 32'h0};
    tab[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0,        6'b011111, 1'b0, 32'h0};
    tab[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 32'h0,        6'b000000, 1'b1, INTV};
    tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0,        6'b000000, 1'b1, EXCV};
    tab[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'ha, 32'h1234,     6'b000000, 1'b1, EXCV};
    tab[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hd, 32'h0,        6'b000000, 1'b1, EXCV};
    tab[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h7, 32'h0,        6'b000000, 1'b1, EXCV};
    tab[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'he, 32'hcafe0000, 6'b000000, 1'b1, 32'hcafe0000};
    tab[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h5555,     6'b000000, 1'b0, 32'h0};

    // Outputs stay quiet while reset is held even with live requests.
    smem = 1'b1; et = 32'h1;
    #2;
    chk("rst_hold_stall", 32'(stall), 32'h0);
    chk("rst_hold_flush", 32'(flush), 32'h0);
    chk("rst_hold_pc", new_pc, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();

    // Vector table; after each flush the drain window ignores all requests.
    foreach (tab[i]) begin
      cyc_exp(tab[i].i_if, tab[i].i_id, tab[i].i_ex, tab[i].i_mem, tab[i].et, tab[i].epc,
              tab[i].stall, tab[i].flush, tab[i].pc);
      if (tab[i].flush)
        for (int j = 0; j < DR; j++) cyc_exp(1, 1, 1, 1, 32'h8, 0, 6'b000000, 1'b0, 32'h0);
    end

    // Async reset mid-drain, then first cycle back is RUN.
    cyc_exp(0, 0, 0, 0, 32'hc, 0, 6'b000000, 1'b1, EXCV);
    drive(0, 1, 0, 1, 32'h1, 0);
    #1 rst = 1'b1;
    #1;
    chk("t1_stall", 32'(stall), 32'h0);
    chk("t1_flush", 32'(flush), 32'h0);
    chk("t1_new_pc", new_pc, 32'h0);
    chk("t1_cycles", stall_cycles, 32'h0);
    #1 rst = 1'b0;
    model_reset();
    cyc_exp(0, 1, 0, 0, 0, 0, 6'b000111, 1'b0, 32'h0);

    // if+ex for three cycles.
    do_reset();
    for (int j = 0; j < 3; j++) cyc_exp(1, 0, 1, 0, 0, 0, 6'b001111, 1'b0, 32'h0);
    chk("t2_cycles", stall_cycles, 32'd3);

    // Overflow exception, drain ignores ex, third cycle honours it.
    cyc_exp(0, 0, 0, 0, 32'hc, 0, 6'b000000, 1'b1, 32'h40);
    cyc_exp(0, 0, 1, 0, 0, 0, 6'b000000, 1'b0, 32'h0);
    cyc_exp(0, 0, 1, 0, 0, 0, 6'b000000, 1'b0, 32'h0);
    cyc_exp(0, 0, 1, 0, 0, 0, 6'b001111, 1'b0, 32'h0);

    // eret deferred behind a memory stall.
    cyc_exp(0, 0, 0, 1, 32'he, 32'h80001234, 6'b011111, 1'b0, 32'h0);
    cyc_exp(0, 0, 0, 1, 32'he, 32'h80001234, 6'b011111, 1'b0, 32'h0);
    cyc_exp(0, 0, 0, 0, 32'he, 32'h80001234, 6'b000000, 1'b1, 32'h80001234);
    for (int j = 0; j < DR; j++) cycle(0, 0, 0, 0, 0, 0);

    // Watchdog with TIMEOUT=4: sticky until reset.
    do_reset();
    for (int j = 1; j <= 4; j++) begin
      cycle(0, 0, 0, 1, 0, 0);
      chk("t5_timeout", 32'(stall_timeout), (j == 4) ? 32'd1 : 32'd0);
    end
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t5_sticky", 32'(stall_timeout), 32'd1);
    do_reset();
    chk("t5_cleared", 32'(stall_timeout), 32'd0);

    // Stall counter wrap.
    force dut.stall_cycles = 32'hfffffffe;
    #1;
    release dut.stall_cycles;
    m_cyc = 32'hfffffffe;
    cycle(1, 0, 0, 0, 0, 0);
    chk("t6_ffff", stall_cycles, 32'hffffffff);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t6_wrap", stall_cycles, 32'h00000000);

    // Randomized traffic against the model, with an occasional reset.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      case ($urandom_range(0, 11))
        4: rx = 32'h1;
        5: rx = 32'h8;
        6: rx = 32'ha;
        7: rx = ($urandom_range(0, 1) != 0) ? 32'hc : 32'hd;
        8: rx = 32'he;
        9: begin rx = $urandom; if (rx == 0) rx = 32'h3; end
        default: rx = 32'h0;
      endcase
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), rx, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
